// File: rtl/result_history.sv
// Four-deep ALU result history with paged hex display and entry browsing.
// Define RESULT_HISTORY_AUTO_SCROLL_EN to add timed automatic page advance.
module result_history #(
    parameter int SCROLL_TICKS = 200000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] result_in,
    input  logic [4:0]  flags_in,
    input  logic        step,
    input  logic        sel,
    input  logic        clear,
    output logic [4:0]  digit3,
    output logic [4:0]  digit2,
    output logic [4:0]  digit1,
    output logic [4:0]  digit0,
    output logic [4:0]  led_flags,
    output logic [2:0]  count
);

    typedef enum logic [1:0] {P_HI, P_LO, P_FLG} page_t;

    logic [36:0] mem [4];
    logic [1:0]  wr_ptr, nxt_wr;
    logic [2:0]  nxt_cnt;
    logic [1:0]  v, nxt_v;
    page_t       page, nxt_page;
    logic        adv, tick;
    logic [1:0]  rd_idx;
    logic [36:0] view;
    logic [31:0] vres;
    logic [4:0]  vflg;
    logic [19:0] nxt_digits;
    logic [4:0]  nxt_led;

`ifdef RESULT_HISTORY_AUTO_SCROLL_EN
    localparam int SW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
    logic [SW-1:0] scroll;

    assign tick = (count != 3'd0) && (scroll == SW'(SCROLL_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            scroll <= '0;
        else if (clear || valid_in || step || count == 3'd0 || tick)
            scroll <= '0;
        else
            scroll <= scroll + 1'b1;
    end
`else
    assign tick = 1'b0;
`endif

    always_comb begin
        nxt_wr   = wr_ptr;
        nxt_cnt  = count;
        nxt_v    = v;
        nxt_page = page;
        adv      = 1'b0;
        if (clear) begin
            nxt_wr   = 2'd0;
            nxt_cnt  = 3'd0;
            nxt_v    = 2'd0;
            nxt_page = P_HI;
        end else if (valid_in) begin
            nxt_wr   = wr_ptr + 2'd1;
            nxt_cnt  = (count == 3'd4) ? 3'd4 : count + 3'd1;
            nxt_v    = 2'd0;
            nxt_page = P_HI;
        end else begin
            if (sel && count > 3'd1)
                nxt_v = ({1'b0, v} == count - 3'd1) ? 2'd0 : v + 2'd1;
            adv = (step && count != 3'd0) || tick;
        end
        if (adv) begin
            unique case (page)
                P_HI:    nxt_page = P_LO;
                P_LO:    nxt_page = P_FLG;
                default: nxt_page = P_HI;
            endcase
        end
    end

    // The newest entry is not in memory yet on a capture edge, so bypass it.
    assign rd_idx = nxt_wr - 2'd1 - nxt_v;
    assign view   = (valid_in && !clear) ? {result_in, flags_in} : mem[rd_idx];
    assign vres   = view[36:5];
    assign vflg   = view[4:0];

    always_comb begin
        nxt_digits = {5'h10, 5'h00, 5'h10, 5'h0E};
        nxt_led    = 5'd0;
        if (nxt_cnt != 3'd0) begin
            nxt_led = vflg;
            unique case (nxt_page)
                P_HI:  nxt_digits = {1'b0, vres[31:28], 1'b0, vres[27:24],
                                     1'b0, vres[23:20], 1'b0, vres[19:16]};
                P_LO:  nxt_digits = {1'b0, vres[15:12], 1'b0, vres[11:8],
                                     1'b0, vres[7:4],   1'b0, vres[3:0]};
                default: nxt_digits = {5'h0F, 3'b000, nxt_v,
                                       4'b0000, vflg[4], 1'b0, vflg[3:0]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in && !clear)
            mem[wr_ptr] <= {result_in, flags_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= 2'd0;
            count     <= 3'd0;
            v         <= 2'd0;
            page      <= P_HI;
            digit3    <= 5'h10;
            digit2    <= 5'h00;
            digit1    <= 5'h10;
            digit0    <= 5'h0E;
            led_flags <= 5'd0;
        end else begin
            wr_ptr    <= nxt_wr;
            count     <= nxt_cnt;
            v         <= nxt_v;
            page      <= nxt_page;
            digit3    <= nxt_digits[19:15];
            digit2    <= nxt_digits[14:10];
            digit1    <= nxt_digits[9:5];
            digit0    <= nxt_digits[4:0];
            led_flags <= nxt_led;
        end
    end

endmodule

// File: tb/tb_result_history.sv
// Directed scoreboard bench for result_history (SCROLL_TICKS=8).
module tb_result_history;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] result_in = '0;
    logic [4:0]  flags_in = '0;
    logic        step = 1'b0;
    logic        sel = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  digit3, digit2, digit1, digit0, led_flags;
    logic [2:0]  count;

    int passed = 0;
    int total = 0;
    logic [27:0] sb [$];

    localparam logic [27:0] NONE = {5'h10, 5'h00, 5'h10, 5'h0E, 5'h00, 3'd0};

    result_history #(.SCROLL_TICKS(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .result_in(result_in),
        .flags_in(flags_in), .step(step), .sel(sel), .clear(clear),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .led_flags(led_flags), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] e_hi(logic [31:0] r, logic [4:0] f, logic [2:0] c);
        return {1'b0, r[31:28], 1'b0, r[27:24], 1'b0, r[23:20], 1'b0, r[19:16], f, c};
    endfunction

    function automatic logic [27:0] e_lo(logic [31:0] r, logic [4:0] f, logic [2:0] c);
        return {1'b0, r[15:12], 1'b0, r[11:8], 1'b0, r[7:4], 1'b0, r[3:0], f, c};
    endfunction

    function automatic logic [27:0] e_flg(logic [1:0] vi, logic [4:0] f, logic [2:0] c);
        return {5'h0F, 3'b000, vi, 4'b0000, f[4], 1'b0, f[3:0], f, c};
    endfunction

    task automatic check(string tag);
        logic [27:0] obs, exp;
        obs = {digit3, digit2, digit1, digit0, led_flags, count};
        exp = sb.pop_front();
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc(string tag, logic va, logic [31:0] r, logic [4:0] f,
                       logic st, logic se, logic cl, logic [27:0] exp);
        @(negedge clk);
        valid_in = va; result_in = r; flags_in = f;
        step = st; sel = se; clear = cl;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        valid_in = 0; step = 0; sel = 0; clear = 0;
        check(tag);
    endtask

    task automatic idle(string tag, logic [27:0] exp);
        cyc(tag, 0, '0, '0, 0, 0, 0, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(NONE);
        check("reset");
        @(negedge clk);
        rst = 0;

        cyc("step_empty", 0, '0, '0, 1, 0, 0, NONE);
        cyc("sel_empty", 0, '0, '0, 0, 1, 0, NONE);

        cyc("cap_hi", 1, 32'h12345678, 5'h11, 0, 0, 0, e_hi(32'h12345678, 5'h11, 1));
        cyc("step_lo", 0, '0, '0, 1, 0, 0, e_lo(32'h12345678, 5'h11, 1));
        cyc("step_flg", 0, '0, '0, 1, 0, 0, e_flg(0, 5'h11, 1));
        cyc("step_wrap", 0, '0, '0, 1, 0, 0, e_hi(32'h12345678, 5'h11, 1));
        cyc("sel_single", 0, '0, '0, 0, 1, 0, e_hi(32'h12345678, 5'h11, 1));
        cyc("clear", 0, '0, '0, 0, 0, 1, NONE);

        for (int i = 1; i <= 5; i++)
            cyc("cap_n", 1, 32'(i), 5'(i), 0, 0, 0,
                e_hi(32'(i), 5'(i), (i > 4) ? 3'd4 : 3'(i)));
        cyc("lo_v0", 0, '0, '0, 1, 0, 0, e_lo(5, 5, 4));
        cyc("sel_v1", 0, '0, '0, 0, 1, 0, e_lo(4, 4, 4));
        cyc("sel_v2", 0, '0, '0, 0, 1, 0, e_lo(3, 3, 4));
        cyc("sel_v3", 0, '0, '0, 0, 1, 0, e_lo(2, 2, 4));
        cyc("sel_wrap", 0, '0, '0, 0, 1, 0, e_lo(5, 5, 4));
        cyc("flg_v0", 0, '0, '0, 1, 0, 0, e_flg(0, 5, 4));
        cyc("sel_step", 0, '0, '0, 1, 1, 0, e_hi(4, 4, 4));
        cyc("sel_step_flg", 0, '0, '0, 1, 0, 0, e_lo(4, 4, 4));
        cyc("sel_step_flg2", 0, '0, '0, 1, 0, 0, e_flg(1, 4, 4));

        cyc("cap_wins", 1, 32'hA0B0C0D0, 5'h1F, 1, 1, 0, e_hi(32'hA0B0C0D0, 5'h1F, 4));
        cyc("cap_wins_lo", 0, '0, '0, 1, 0, 0, e_lo(32'hA0B0C0D0, 5'h1F, 4));
        cyc("cap_wins_v0", 0, '0, '0, 1, 0, 0, e_flg(0, 5'h1F, 4));
        cyc("clear_wins", 1, 32'h55555555, 5'h05, 0, 0, 1, NONE);
        cyc("after_clear", 0, '0, '0, 0, 0, 0, NONE);

        cyc("cap_pre_rst", 1, 32'hCAFEF00D, 5'h0A, 0, 0, 0, e_hi(32'hCAFEF00D, 5'h0A, 1));
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        sb.push_back(NONE);
        check("async_rst");
        @(negedge clk);
        valid_in = 1; result_in = 32'h99999999; flags_in = 5'h09;
        @(posedge clk);
        #1;
        valid_in = 0;
        rst = 0;
        sb.push_back(NONE);
        check("cap_in_rst");
        idle("post_rst", NONE);

        cyc("cap_scroll", 1, 32'h0BADBEEF, 5'h12, 0, 0, 0, e_hi(32'h0BADBEEF, 5'h12, 1));
`ifdef RESULT_HISTORY_AUTO_SCROLL_EN
        for (int i = 0; i < 7; i++) idle("hold_hi", e_hi(32'h0BADBEEF, 5'h12, 1));
        idle("auto_lo", e_lo(32'h0BADBEEF, 5'h12, 1));
        for (int i = 0; i < 7; i++) idle("hold_lo", e_lo(32'h0BADBEEF, 5'h12, 1));
        idle("auto_flg", e_flg(0, 5'h12, 1));
        for (int i = 0; i < 4; i++) idle("pre_step", e_flg(0, 5'h12, 1));
        cyc("step_restart", 0, '0, '0, 1, 0, 0, e_hi(32'h0BADBEEF, 5'h12, 1));
        for (int i = 0; i < 7; i++) idle("hold_restart", e_hi(32'h0BADBEEF, 5'h12, 1));
        idle("auto_after_step", e_lo(32'h0BADBEEF, 5'h12, 1));
        for (int i = 0; i < 3; i++) idle("run", e_lo(32'h0BADBEEF, 5'h12, 1));
`else
        for (int i = 0; i < 20; i++) idle("no_scroll", e_hi(32'h0BADBEEF, 5'h12, 1));
`endif
        #2;
        rst = 1;
        #1;
        sb.push_back(NONE);
        check("rst_mid_run");
        @(negedge clk);
        rst = 0;
        idle("rst_idle", NONE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/result_history.md
RESULT_HISTORY -- requirements
Module: result_history

Interface
REQ-001 Parameter SCROLL_TICKS, default 200000000: clk cycles per automatic page advance (2 s at 100 MHz); used only when the Configuration macro is defined.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 valid_in  in  1  single-cycle strobe; ALU result_in/flags_in valid this cycle.
REQ-005 result_in  in  32  ALU result word.
REQ-006 flags_in  in  5  ALU flags.
REQ-007 step  in  1  single-cycle debounced pulse; advance display page.
REQ-008 sel  in  1  single-cycle debounced pulse; browse to next-older stored entry.
REQ-009 clear  in  1  single-cycle synchronous pulse; empty the history.
REQ-010 digit3, digit2, digit1, digit0  out  5 each  registered 5-bit character codes for the display driver (0x00-0x0F hex, 0x10 n, 0x14 blank).
REQ-011 led_flags  out  5  registered flags of the viewed entry.
REQ-012 count  out  3  registered number of stored entries, 0..4.

Function
REQ-013 Storage SHALL be a 4-entry circular buffer of {result,flags}, with a 2-bit write pointer wr_ptr and an entry count of 0..4.
REQ-014 On valid_in: write to wr_ptr; wr_ptr <= wr_ptr+1 mod 4; count saturates at 4, and when full the oldest entry is overwritten.
REQ-015 On capture, view index SHALL reset to 0 (newest) and page SHALL reset to P_HI.
REQ-016 View index v selects entry (wr_ptr-1-v) mod 4.
REQ-017 sel: v <= v+1, wrapping to 0 after count-1; sel is ignored when count<=1.
REQ-018 Page state machine: P_HI -> P_LO -> P_FLG -> P_HI on each step; step is ignored when count=0.
REQ-019 P_HI: digit3..0 = {0,nibble} of result[31:28], [27:24], [23:20], [19:16].
REQ-020 P_LO: digit3..0 = {0,nibble} of result[15:12] down to [3:0].
REQ-021 P_FLG: digit3=0x0F, digit2={000,v}, digit1={0000,flags[4]}, digit0={0,flags[3:0]}.
REQ-022 count=0: digits SHALL be 0x10,0x00,0x10,0x0E ("n0nE") and led_flags=0, regardless of page.
REQ-023 led_flags SHALL equal the flags of the viewed entry when count>0.
REQ-024 All outputs SHALL reflect any event one clk cycle after the edge at which the event is sampled (latency 1).
REQ-025 clear: count<=0, v<=0, page<=P_HI, wr_ptr<=0; stored data is don't-care.
REQ-026 Priority in the same cycle: clear > valid_in > sel > step; valid_in discards a coincident sel or step.
REQ-027 sel and step in the same cycle (no capture, no clear) SHALL both take effect.

Reset
REQ-028 On rst assertion, without waiting for clk: wr_ptr=0, count=0, v=0, page=P_HI, digits=0x10,0x00,0x10,0x0E, led_flags=0, scroll counter=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries, and a valid_in coincident with rst SHALL be lost.

Configuration
REQ-030 Macro RESULT_HISTORY_AUTO_SCROLL_EN defined: a scroll counter counts clk cycles while count>0.
REQ-031 When the counter reaches SCROLL_TICKS-1, the page SHALL advance exactly as on step and the counter SHALL return to 0.
REQ-032 The counter SHALL be zeroed by step, valid_in, clear, or count=0.
REQ-033 Macro undefined: no counter logic exists, and the page changes only via step, capture, or clear.

Verification
REQ-034 Reset, then one valid_in with result_in=0x12345678, flags_in=0x11 -> next cycle digits 1,2,3,4; count=1; led_flags=0x11.
REQ-035 From REQ-034 state, step twice -> digits 5,6,7,8, then 0x0F,0x00,0x01,0x01; a third step returns to 1,2,3,4.
REQ-036 Five captures of 0x00000001..0x00000005 -> count=4; sel x3 views 0x4,0x3,0x2 on P_LO; a fourth sel wraps to 0x5.
REQ-037 valid_in, step and sel all in one cycle -> new entry shown on P_HI with v=0; clear together with valid_in -> count=0, "n0nE".
REQ-038 With the macro defined and SCROLL_TICKS=8, count=1 -> page advances every 8 cycles; a step at cycle 5 restarts the interval; rst pulsed mid-run -> "n0nE" immediately.
